// File: rtl/pu_slave_spi_bank_ctrl.sv
// Ping-pong send-bank sequencer for the SPI slave PU: NITTA fills one bank while SPI drains the
// other; banks swap on signal_cycle, deferred until the SPI frame ends (cs high).
module pu_slave_spi_bank_ctrl #(
    parameter int BUF_SIZE   = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_cycle,
    input  logic                  signal_wr,
    input  logic                  cs,
    input  logic                  rd_req,
    output logic                  buf_sel,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_len,
    output logic                  swap_pending,
    output logic                  frame_done,
    output logic                  flag_overflow,
    output logic                  flag_underrun,
    output logic                  flag_cycle_lost
);

    localparam logic [ADDR_WIDTH:0] BUF_LEN = (ADDR_WIDTH + 1)'(BUF_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state, state_next;

    // Pointers carry one extra bit so a full bank (ptr == BUF_SIZE) is representable.
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                cs_q;

    logic swap;
    logic overflow_set;
    logic underrun_set;
    logic cycle_lost_set;

    assign wr_en        = signal_wr && (wr_ptr < BUF_LEN);
    assign wr_addr      = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_en        = rd_req && !cs && (rd_ptr < rd_len);
    assign rd_addr      = rd_ptr[ADDR_WIDTH-1:0];
    assign swap_pending = (state == PEND);
    assign frame_done   = cs && !cs_q;

    assign overflow_set   = signal_wr && !wr_en;
    assign underrun_set   = rd_req && !cs && (rd_ptr >= rd_len);
    assign cycle_lost_set = (state == PEND) && signal_cycle;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and
    // synthesis cannot infer a latch.
    always_comb begin
        state_next = state;
        swap       = 1'b0;
        case (state)
            IDLE: begin
                if (signal_cycle) begin
                    if (cs) swap = 1'b1;
                    else    state_next = PEND;
                end
            end
            PEND: begin
                if (cs) begin
                    swap       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            buf_sel         <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rd_len          <= '0;
            cs_q            <= 1'b1;
            flag_overflow   <= 1'b0;
            flag_underrun   <= 1'b0;
            flag_cycle_lost <= 1'b0;
        end else begin
            state <= state_next;
            cs_q  <= cs;

            if (swap) begin
                buf_sel <= !buf_sel;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                // A write landing on the swap edge goes to the outgoing bank and must be counted.
                rd_len  <= wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_en};
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            end

            // Setting wins over the swap-time clear.
            if (overflow_set)  flag_overflow <= 1'b1;
            else if (swap)     flag_overflow <= 1'b0;

            if (underrun_set)  flag_underrun <= 1'b1;
            else if (swap)     flag_underrun <= 1'b0;

            if (cycle_lost_set) flag_cycle_lost <= 1'b1;
        end
    end

endmodule
